// File: rtl/mem_lsu.sv
// Registered MEM stage with integrated load/store unit: pass-through to WB, req/ack data bus
// sequencing, big-endian load alignment/extension, LL/SC link bit and a bus watchdog.
module mem_lsu #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [3:0]            mem_op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           store_data_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic [31:0]           hi_i,
    input  logic [31:0]           lo_i,
    input  logic                  whilo_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic [31:0]           hi_o,
    output logic [31:0]           lo_o,
    output logic                  whilo_o,
    output logic                  stall_req_o,
    output logic                  dbus_req_o,
    output logic                  dbus_we_o,
    output logic [ADDR_W-1:0]     dbus_addr_o,
    output logic [3:0]            dbus_sel_o,
    output logic [31:0]           dbus_wdata_o,
    input  logic [31:0]           dbus_rdata_i,
    input  logic                  dbus_ack_i,
    output logic                  adel_o,
    output logic                  ades_o,
    output logic                  bus_err_o
);

    typedef enum logic {
        S_IDLE,
        S_BUS
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8,
        OP_LL   = 4'd9,
        OP_SC   = 4'd10
    } mem_op_e;

    localparam int unsigned          CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic                    llbit_q, llbit_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    mem_op_e                 op_q, op_d;
    logic [1:0]              lane_q, lane_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       baddr_q, baddr_d;
    logic [3:0]              sel_q, sel_d;
    logic [31:0]             bwdata_q, bwdata_d;

    logic [REG_ADDR_W-1:0]   wd_q, wd_d;
    logic                    wreg_q, wreg_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             hi_q, hi_d;
    logic [31:0]             lo_q, lo_d;
    logic                    whilo_q, whilo_d;
    logic                    adel_q, adel_d;
    logic                    ades_q, ades_d;
    logic                    bus_err_q, bus_err_d;

    logic                    is_load, is_store, is_byte, is_half, is_word, is_mem, misalign;
    logic [3:0]              req_sel;
    logic [31:0]             req_wdata;
    logic [31:0]             rshift;
    logic [7:0]              byte_v;
    logic [15:0]             half_v;
    logic [31:0]             load_val;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (mem_op_i)
            OP_LB, OP_LBU:        begin is_load  = 1'b1; is_byte = 1'b1; end
            OP_LH, OP_LHU:        begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LW, OP_LL:         begin is_load  = 1'b1; is_word = 1'b1; end
            OP_SB:                begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:                begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW, OP_SC:         begin is_store = 1'b1; is_word = 1'b1; end
            default:              ;
        endcase
        is_mem   = is_load | is_store;
        misalign = (is_half & mem_addr_i[0]) | (is_word & (|mem_addr_i[1:0]));

        // Big-endian lanes: byte offset 0 lives in data[31:24] and is enabled by sel[3].
        if (is_byte) begin
            req_sel   = 4'b1000 >> mem_addr_i[1:0];
            req_wdata = {4{store_data_i[7:0]}};
        end else if (is_half) begin
            req_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            req_wdata = {2{store_data_i[15:0]}};
        end else begin
            req_sel   = 4'b1111;
            req_wdata = store_data_i;
        end
    end

    always_comb begin
        rshift = dbus_rdata_i >> {~lane_q, 3'b000};
        byte_v = rshift[7:0];
        half_v = lane_q[1] ? dbus_rdata_i[15:0] : dbus_rdata_i[31:16];
        case (op_q)
            OP_LB:   load_val = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_val = {24'h000000, byte_v};
            OP_LH:   load_val = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_val = {16'h0000, half_v};
            default: load_val = dbus_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        llbit_d     = llbit_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        lane_d      = lane_q;
        we_d        = we_q;
        baddr_d     = baddr_q;
        sel_d       = sel_q;
        bwdata_d    = bwdata_q;
        stall_req_o = 1'b0;
        wd_d        = '0;
        wreg_d      = 1'b0;
        wdata_d     = '0;
        hi_d        = '0;
        lo_d        = '0;
        whilo_d     = 1'b0;
        adel_d      = 1'b0;
        ades_d      = 1'b0;
        bus_err_d   = 1'b0;

        if (flush_i) begin
            state_d  = S_IDLE;
            llbit_d  = 1'b0;
            cnt_d    = '0;
            we_d     = 1'b0;
            baddr_d  = '0;
            sel_d    = '0;
            bwdata_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!valid_i || !is_mem) begin
                        wd_d    = wd_i;
                        wreg_d  = wreg_i & valid_i;
                        wdata_d = wdata_i;
                        hi_d    = hi_i;
                        lo_d    = lo_i;
                        whilo_d = whilo_i & valid_i;
                    end else if (misalign) begin
                        wd_d    = wd_i;
                        wdata_d = wdata_i;
                        hi_d    = hi_i;
                        lo_d    = lo_i;
                        adel_d  = is_load;
                        ades_d  = is_store;
                    end else if (mem_op_i == OP_SC && !llbit_q) begin
                        // Failed SC completes locally: rt <= 0 without touching the bus.
                        wd_d    = wd_i;
                        wreg_d  = 1'b1;
                        hi_d    = hi_i;
                        lo_d    = lo_i;
                        whilo_d = whilo_i;
                    end else begin
                        stall_req_o = 1'b1;
                        state_d     = S_BUS;
                        cnt_d       = '0;
                        op_d        = mem_op_e'(mem_op_i);
                        lane_d      = mem_addr_i[1:0];
                        we_d        = is_store;
                        baddr_d     = {mem_addr_i[ADDR_W-1:2], 2'b00};
                        sel_d       = req_sel;
                        bwdata_d    = req_wdata;
                    end
                end
                S_BUS: begin
                    if (dbus_ack_i) begin
                        state_d  = S_IDLE;
                        cnt_d    = '0;
                        we_d     = 1'b0;
                        baddr_d  = '0;
                        sel_d    = '0;
                        bwdata_d = '0;
                        wd_d     = wd_i;
                        hi_d     = hi_i;
                        lo_d     = lo_i;
                        whilo_d  = whilo_i;
                        case (op_q)
                            OP_SC: begin
                                wreg_d  = 1'b1;
                                wdata_d = 32'd1;
                                llbit_d = 1'b0;
                            end
                            OP_SB, OP_SH, OP_SW: begin
                                wreg_d  = 1'b0;
                                wdata_d = wdata_i;
                            end
                            default: begin
                                wreg_d  = wreg_i;
                                wdata_d = load_val;
                                if (op_q == OP_LL) llbit_d = 1'b1;
                            end
                        endcase
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        we_d      = 1'b0;
                        baddr_d   = '0;
                        sel_d     = '0;
                        bwdata_d  = '0;
                        bus_err_d = 1'b1;
                    end else begin
                        stall_req_o = 1'b1;
                        cnt_d       = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            llbit_q   <= 1'b0;
            cnt_q     <= '0;
            op_q      <= OP_NONE;
            lane_q    <= '0;
            we_q      <= 1'b0;
            baddr_q   <= '0;
            sel_q     <= '0;
            bwdata_q  <= '0;
            wd_q      <= '0;
            wreg_q    <= 1'b0;
            wdata_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            whilo_q   <= 1'b0;
            adel_q    <= 1'b0;
            ades_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            llbit_q   <= llbit_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            lane_q    <= lane_d;
            we_q      <= we_d;
            baddr_q   <= baddr_d;
            sel_q     <= sel_d;
            bwdata_q  <= bwdata_d;
            wd_q      <= wd_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            whilo_q   <= whilo_d;
            adel_q    <= adel_d;
            ades_q    <= ades_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign dbus_req_o   = (state_q == S_BUS);
    assign dbus_we_o    = we_q;
    assign dbus_addr_o  = baddr_q;
    assign dbus_sel_o   = sel_q;
    assign dbus_wdata_o = bwdata_q;
    assign wd_o         = wd_q;
    assign wreg_o       = wreg_q;
    assign wdata_o      = wdata_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign whilo_o      = whilo_q;
    assign adel_o       = adel_q;
    assign ades_o       = ades_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed scenarios plus random ops checked against a byte-addressed
// big-endian memory model with an LL/SC link flag.
module tb_mem_lsu;

    localparam int unsigned TO = 4;

    localparam logic [3:0] T_NONE = 4'd0, T_LB = 4'd1, T_LBU = 4'd2, T_LH = 4'd3, T_LHU = 4'd4,
                           T_LW = 4'd5, T_SB = 4'd6, T_SH = 4'd7, T_SW = 4'd8, T_LL = 4'd9,
                           T_SC = 4'd10;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, wreg_i, whilo_i, flush_i, dbus_ack_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i, store_data_i, wdata_i, hi_i, lo_i, dbus_rdata_i;
    logic [4:0]  wd_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stall_req_o, dbus_req_o, dbus_we_o, adel_o, ades_o, bus_err_o;
    logic [31:0] wdata_o, hi_o, lo_o, dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_sel_o;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] mem [logic [31:0]];
    bit         llbit_m;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
        .store_data_i(store_data_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .flush_i(flush_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
        .whilo_o(whilo_o), .stall_req_o(stall_req_o), .dbus_req_o(dbus_req_o),
        .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o), .dbus_sel_o(dbus_sel_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i),
        .adel_o(adel_o), .ades_o(ades_o), .bus_err_o(bus_err_o)
    );

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = 8'($urandom);
        return mem[a];
    endfunction

    function automatic int unsigned op_size(input logic [3:0] op);
        case (op)
            T_LB, T_LBU, T_SB:        return 1;
            T_LH, T_LHU, T_SH:        return 2;
            T_LW, T_SW, T_LL, T_SC:   return 4;
            default:                  return 0;
        endcase
    endfunction

    function automatic bit op_is_load(input logic [3:0] op);
        return op inside {T_LB, T_LBU, T_LH, T_LHU, T_LW, T_LL};
    endfunction

    // One instruction from accept to WB; waitc = BUS cycles before ack.
    task automatic mem_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                           input int unsigned waitc, input bit vld);
        int unsigned sz  = op_size(op);
        bit          ld  = op_is_load(op);
        bit          st  = (sz != 0) && !ld;
        bit          mis = (sz > 1) && ((addr % sz) != 0);
        bit          go  = vld && (sz != 0) && !mis && !(op == T_SC && !llbit_m);
        bit          e_wreg = 1'b0, e_whilo = 1'b0, e_adel = 1'b0, e_ades = 1'b0, chk = 1'b0;
        logic [31:0] e_data = '0, v = '0, a0, rword = '0, e_bw = '0;
        logic [3:0]  e_sel = '0;

        valid_i = vld; mem_op_i = op; mem_addr_i = addr; store_data_i = sdata;
        wd_i = 5'($urandom); wreg_i = 1'($urandom); wdata_i = $urandom;
        hi_i = $urandom; lo_i = $urandom; whilo_i = 1'($urandom);
        flush_i = 1'b0; dbus_ack_i = 1'b0; dbus_rdata_i = $urandom;

        a0 = addr & ~32'd3;
        if (go) begin
            rword = {rd_byte(a0), rd_byte(a0 + 1), rd_byte(a0 + 2), rd_byte(a0 + 3)};
            for (int i = 0; i < int'(sz); i++) begin
                int idx = 3 - int'((addr + i) & 32'd3);
                e_sel[idx] = 1'b1;
                v = (v << 8) | {24'h0, rd_byte(addr + i)};
            end
            e_bw = (sz == 1) ? {4{sdata[7:0]}} : (sz == 2) ? {2{sdata[15:0]}} : sdata;
            if (op == T_LB) v = {{24{v[7]}}, v[7:0]};
            if (op == T_LH) v = {{16{v[15]}}, v[15:0]};
        end

        if (!vld || sz == 0) begin
            e_wreg = wreg_i & vld; e_whilo = whilo_i & vld; e_data = wdata_i; chk = 1'b1;
        end else if (mis) begin
            e_adel = ld; e_ades = st;
        end else if (op == T_SC && !llbit_m) begin
            e_wreg = 1'b1; e_data = 32'd0; e_whilo = whilo_i; chk = 1'b1;
        end else if (ld) begin
            e_wreg = wreg_i; e_data = v; e_whilo = whilo_i; chk = 1'b1;
        end else if (op == T_SC) begin
            e_wreg = 1'b1; e_data = 32'd1; e_whilo = whilo_i; chk = 1'b1;
        end else begin
            e_whilo = whilo_i;
        end

        #1;
        nvec++;
        if (stall_req_o !== go) begin
            nerr++; $display("FAIL accept_stall op=%0d addr=%h got %b exp %b", op, addr, stall_req_o, go);
        end
        if (go) begin
            for (int k = 0; k <= int'(waitc); k++) begin
                @(posedge clk); #1;
                nvec++;
                if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o} !== {1'b1, st, a0, e_sel}) begin
                    nerr++;
                    $display("FAIL bus_ctrl op=%0d got req=%b we=%b addr=%h sel=%b exp 1 %b %h %b",
                             op, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o, st, a0, e_sel);
                end
                if (st) begin
                    nvec++;
                    if (dbus_wdata_o !== e_bw) begin
                        nerr++; $display("FAIL bus_wdata op=%0d got %h exp %h", op, dbus_wdata_o, e_bw);
                    end
                end
                if (k == int'(waitc)) begin
                    dbus_ack_i = 1'b1; dbus_rdata_i = rword;
                end else begin
                    dbus_rdata_i = $urandom;
                end
                #1;
                nvec++;
                if (stall_req_o !== (k != int'(waitc))) begin
                    nerr++; $display("FAIL bus_stall op=%0d k=%0d got %b exp %b", op, k, stall_req_o, k != int'(waitc));
                end
            end
        end
        @(posedge clk); #1;
        nvec++;
        if ({wreg_o, whilo_o, adel_o, ades_o, bus_err_o, dbus_req_o} !==
            {e_wreg, e_whilo, e_adel, e_ades, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL wb_ctrl op=%0d addr=%h got wreg,whilo,adel,ades,buserr,req=%b%b%b%b%b%b exp %b%b%b%b00",
                     op, addr, wreg_o, whilo_o, adel_o, ades_o, bus_err_o, dbus_req_o,
                     e_wreg, e_whilo, e_adel, e_ades);
        end
        if (chk) begin
            nvec++;
            if ({wd_o, wdata_o} !== {wd_i, e_data}) begin
                nerr++; $display("FAIL wb_data op=%0d got wd=%0d data=%h exp wd=%0d data=%h", op, wd_o, wdata_o, wd_i, e_data);
            end
        end
        if (e_whilo) begin
            nvec++;
            if ({hi_o, lo_o} !== {hi_i, lo_i}) begin
                nerr++; $display("FAIL hilo got %h %h exp %h %h", hi_o, lo_o, hi_i, lo_i);
            end
        end

        if (go && st)
            for (int i = 0; i < int'(sz); i++) mem[addr + i] = 8'(sdata >> (8 * (int'(sz) - 1 - i)));
        if (go && op == T_LL) llbit_m = 1'b1;
        if (go && op == T_SC) llbit_m = 1'b0;
        valid_i = 1'b0; mem_op_i = T_NONE; dbus_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; valid_i = 1'b0; mem_op_i = T_NONE; mem_addr_i = '0; store_data_i = '0;
        wd_i = '0; wreg_i = 1'b0; wdata_i = '0; hi_i = '0; lo_i = '0; whilo_i = 1'b0;
        flush_i = 1'b0; dbus_ack_i = 1'b0; dbus_rdata_i = '0; llbit_m = 1'b0;
        #3;
        nvec++;
        if ({wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, stall_req_o, dbus_req_o, dbus_we_o,
             dbus_addr_o, dbus_sel_o, dbus_wdata_o, adel_o, ades_o, bus_err_o} !== '0) begin
            nerr++; $display("FAIL reset_state got wreg=%b req=%b wdata=%h exp all zero", wreg_o, dbus_req_o, wdata_o);
        end
        #9 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_examples();
        logic [31:0] base = 32'h0000_1000;
        mem[base] = 8'h12; mem[base + 1] = 8'h80; mem[base + 2] = 8'h34; mem[base + 3] = 8'h56;
        mem_txn(T_LB, base + 1, 32'h0, 0, 1'b1);
        nvec++;
        if (wdata_o !== 32'hFFFF_FF80) begin
            nerr++; $display("FAIL lb_example got %h exp ffffff80", wdata_o);
        end
        mem_txn(T_SH, base + 2, 32'h0000_BEEF, 1, 1'b1);
        mem_txn(T_LW, base, 32'h0, 0, 1'b1);
        nvec++;
        if (wdata_o !== 32'h1280_BEEF) begin
            nerr++; $display("FAIL sh_readback got %h exp 1280beef", wdata_o);
        end
        mem_txn(T_LW, base + 6, 32'h0, 0, 1'b1);
        mem_txn(T_SW, base + 1, 32'h1234_5678, 0, 1'b1);
        mem_txn(T_LHU, base + 3, 32'h0, 0, 1'b1);
    endtask

    task automatic test_llsc();
        mem_txn(T_LL, 32'h0000_1100, 32'h0, 2, 1'b1);
        mem_txn(T_SC, 32'h0000_1104, 32'hCAFE_F00D, 1, 1'b1);
        nvec++;
        if (wdata_o !== 32'd1) begin
            nerr++; $display("FAIL sc_success got %h exp 1", wdata_o);
        end
        mem_txn(T_SC, 32'h0000_1108, 32'hDEAD_BEEF, 0, 1'b1);
        nvec++;
        if ({wreg_o, wdata_o} !== {1'b1, 32'd0}) begin
            nerr++; $display("FAIL sc_fail got wreg=%b data=%h exp 1 0", wreg_o, wdata_o);
        end
        mem_txn(T_LW, 32'h0000_1104, 32'h0, 0, 1'b1);
    endtask

    task automatic test_timeout();
        valid_i = 1'b1; mem_op_i = T_LW; mem_addr_i = 32'h0000_1200; wreg_i = 1'b1; whilo_i = 1'b1;
        dbus_ack_i = 1'b0;
        for (int k = 0; k < int'(TO); k++) begin
            @(posedge clk); #1;
            nvec++;
            if ({dbus_req_o, stall_req_o} !== {1'b1, k < int'(TO) - 1}) begin
                nerr++; $display("FAIL wd_wait k=%0d got req=%b stall=%b exp 1 %b", k, dbus_req_o, stall_req_o, k < int'(TO) - 1);
            end
        end
        @(posedge clk); #1;
        nvec++;
        if ({bus_err_o, dbus_req_o, wreg_o, whilo_o} !== 4'b1000) begin
            nerr++; $display("FAIL wd_abort got err,req,wreg,whilo=%b%b%b%b exp 1000", bus_err_o, dbus_req_o, wreg_o, whilo_o);
        end
        valid_i = 1'b0; mem_op_i = T_NONE; dbus_ack_i = 1'b1;
        #1;
        nvec++;
        if (stall_req_o !== 1'b0) begin
            nerr++; $display("FAIL wd_release got %b exp 0", stall_req_o);
        end
        @(posedge clk); #1;
        dbus_ack_i = 1'b0;
        nvec++;
        if ({bus_err_o, dbus_req_o, stall_req_o} !== 3'b000) begin
            nerr++; $display("FAIL idle_ack got err,req,stall=%b%b%b exp 000", bus_err_o, dbus_req_o, stall_req_o);
        end
        mem_txn(T_LBU, 32'h0000_1203, 32'h0, 3, 1'b1);
    endtask

    task automatic test_flush();
        mem_txn(T_LL, 32'h0000_1300, 32'h0, 0, 1'b1);
        valid_i = 1'b1; mem_op_i = T_LW; mem_addr_i = 32'h0000_1300; wreg_i = 1'b1; whilo_i = 1'b1;
        @(posedge clk); #1;
        nvec++;
        if (dbus_req_o !== 1'b1) begin
            nerr++; $display("FAIL flush_pre_req got %b exp 1", dbus_req_o);
        end
        flush_i = 1'b1; dbus_ack_i = 1'b1; dbus_rdata_i = $urandom;
        #1;
        nvec++;
        if (stall_req_o !== 1'b0) begin
            nerr++; $display("FAIL flush_stall got %b exp 0", stall_req_o);
        end
        @(posedge clk); #1;
        flush_i = 1'b0; dbus_ack_i = 1'b0; valid_i = 1'b0; mem_op_i = T_NONE;
        llbit_m = 1'b0;
        nvec++;
        if ({dbus_req_o, wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o} !== '0) begin
            nerr++; $display("FAIL flush_bubble got req=%b wreg=%b wdata=%h whilo=%b exp zeros", dbus_req_o, wreg_o, wdata_o, whilo_o);
        end
        mem_txn(T_SC, 32'h0000_1300, 32'h5555_AAAA, 0, 1'b1);
        valid_i = 1'b1; mem_op_i = T_NONE; wreg_i = 1'b1; whilo_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        nvec++;
        if ({wreg_o, whilo_o} !== 2'b00) begin
            nerr++; $display("FAIL flush_idle got wreg=%b whilo=%b exp 00", wreg_o, whilo_o);
        end
    endtask

    task automatic test_async_reset();
        mem_txn(T_LL, 32'h0000_1400, 32'h0, 1, 1'b1);
        valid_i = 1'b1; mem_op_i = T_SW; mem_addr_i = 32'h0000_1404; store_data_i = 32'h0BAD_F00D;
        @(posedge clk); #1;
        nvec++;
        if (dbus_req_o !== 1'b1) begin
            nerr++; $display("FAIL rst_pre_req got %b exp 1", dbus_req_o);
        end
        valid_i = 1'b0; mem_op_i = T_NONE;
        #2 rst = 1'b0;
        #1;
        llbit_m = 1'b0;
        nvec++;
        if ({dbus_req_o, stall_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o, wd_o, wreg_o,
             wdata_o, hi_o, lo_o, whilo_o, adel_o, ades_o, bus_err_o} !== '0) begin
            nerr++; $display("FAIL async_rst got req=%b we=%b sel=%b wreg=%b exp zeros", dbus_req_o, dbus_we_o, dbus_sel_o, wreg_o);
        end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        mem_txn(T_SC, 32'h0000_1400, 32'h7777_7777, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            mem_txn(4'($urandom_range(1, 8)), 32'h0000_1500 + ($urandom_range(0, 7) * 4), $urandom, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            logic [3:0]  op   = 4'($urandom_range(0, 10));
            logic [31:0] addr = 32'h0000_2000 + $urandom_range(0, 31);
            if (op == T_SC) addr = addr & ~32'd3;
            mem_txn(op, addr, $urandom, $urandom_range(0, TO - 1), $urandom_range(0, 7) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_examples();
        test_llsc();
        test_timeout();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
